// File: rtl/ui_pkg.sv
// Shared types and constants for the manual time-setting front end.
// State encoding, field codes for sethms and key positions on the KEY bus.
package ui_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10,
    SET_SEC  = 2'b11
  } ui_state_t;

  localparam logic [1:0] FIELD_SEC  = 2'b00;
  localparam logic [1:0] FIELD_MIN  = 2'b01;
  localparam logic [1:0] FIELD_HOUR = 2'b10;

  localparam int KEY_UP   = 0;
  localparam int KEY_DN   = 1;
  localparam int KEY_NEXT = 2;
  localparam int KEY_MODE = 3;

  // Field rotation used by the next-field key: hour -> min -> sec -> hour.
  function automatic ui_state_t next_field(input ui_state_t cur);
    case (cur)
      SET_HOUR: next_field = SET_MIN;
      SET_MIN:  next_field = SET_SEC;
      SET_SEC:  next_field = SET_HOUR;
      default:  next_field = SET_HOUR;
    endcase
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: 2-flop synchronizer, stability counter and press-event detect.
// Output level is active-high; press is a one-cycle pulse on released->pressed.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic level,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          press_r;
  logic [CW-1:0] cnt_r;
  logic          raw_s;
  logic          differ_s;
  logic          flip_s;

  assign raw_s    = ~sync2_r;
  assign differ_s = (raw_s != level_r);
  // The level only moves once the new value has been seen DEBOUNCE_CYCLES times in a row.
  assign flip_s   = differ_s && (cnt_r == CW'(DEBOUNCE_CYCLES));

  // Synchronizer, stability counter, debounced level and press pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      level_r <= 1'b0;
      press_r <= 1'b0;
      cnt_r   <= '0;
    end else begin
      sync1_r <= key_raw;
      sync2_r <= sync1_r;
      press_r <= flip_s & raw_s;
      if (flip_s) begin
        level_r <= raw_s;
        cnt_r   <= '0;
      end else if (differ_s) begin
        cnt_r   <= cnt_r + CW'(1);
      end else begin
        cnt_r   <= '0;
      end
    end
  end

  assign level = level_r;
  assign press = press_r;

endmodule

// File: rtl/ui_set_controller.sv
// Key-driven time-setting sequencer: debounced keys, field FSM, step pulses, blink mask.
// Optional auto-repeat of held up/down keys is enabled by defining UI_AUTO_REPEAT_EN.
module ui_set_controller
  import ui_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES      = 500000,
  parameter int unsigned REPEAT_DELAY_CYCLES  = 25000000,
  parameter int unsigned REPEAT_PERIOD_CYCLES = 5000000,
  parameter int unsigned TIMEOUT_CYCLES       = 500000000,
  parameter int unsigned BLINK_HALF_CYCLES    = 12500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] button,
  output logic       set,
  output logic [1:0] sethms,
  output logic [1:0] upDown,
  output logic       blink,
  output logic [3:0] pressed
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned BLK_W = $clog2(BLINK_HALF_CYCLES + 1);

  if ((DEBOUNCE_CYCLES == 0) || (REPEAT_DELAY_CYCLES == 0) || (REPEAT_PERIOD_CYCLES == 0) ||
      (TIMEOUT_CYCLES == 0) || (BLINK_HALF_CYCLES == 0)) begin : g_bad_cfg
    $error("ui_set_controller: all cycle-count parameters must be non-zero");
  end

  logic [3:0]       level_s;
  logic [3:0]       ev_s;
  ui_state_t        state_r;
  ui_state_t        next_state_s;
  logic             in_set_s;
  logic             stay_s;
  logic             timeout_s;
  logic             step_up_s;
  logic             step_dn_s;
  logic             rpt_due_s;
  logic             rpt_dn_s;
  logic             rpt_fire_s;
  logic [TMO_W-1:0] tmo_cnt_r;
  logic [BLK_W-1:0] blink_cnt_r;
  logic             set_r;
  logic [1:0]       sethms_r;
  logic [1:0]       ud_r;
  logic             blink_r;

  for (genvar k = 0; k < 4; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .clk    (clk),
      .reset  (reset),
      .key_raw(button[k]),
      .level  (level_s[k]),
      .press  (ev_s[k])
    );
  end

  assign in_set_s  = (state_r != RUN);
  assign stay_s    = (next_state_s == state_r);
  // Any press or repeat pulse in the same cycle pre-empts the idle timeout.
  assign timeout_s = in_set_s && (ev_s == 4'b0000) && !rpt_due_s &&
                     (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));
  assign step_up_s = in_set_s && ev_s[KEY_UP] && !ev_s[KEY_DN] && !ev_s[KEY_MODE];
  assign step_dn_s = in_set_s && ev_s[KEY_DN] && !ev_s[KEY_UP] && !ev_s[KEY_MODE];
  assign rpt_fire_s = rpt_due_s && stay_s;

  // Next-state decode; the mode key outranks both timeout and next-field.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      RUN: begin
        if (ev_s[KEY_MODE]) begin
          next_state_s = SET_HOUR;
        end else begin
          next_state_s = RUN;
        end
      end
      SET_HOUR, SET_MIN, SET_SEC: begin
        if (ev_s[KEY_MODE] || timeout_s) begin
          next_state_s = RUN;
        end else if (ev_s[KEY_NEXT]) begin
          next_state_s = next_field(state_r);
        end else begin
          next_state_s = state_r;
        end
      end
      default: next_state_s = RUN;
    endcase
  end

  // State register and registered set/field/step outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= RUN;
      set_r    <= 1'b0;
      sethms_r <= FIELD_SEC;
      ud_r     <= 2'b00;
    end else begin
      state_r  <= next_state_s;
      set_r    <= (next_state_s != RUN);
      ud_r     <= {step_dn_s | (rpt_fire_s & rpt_dn_s), step_up_s | (rpt_fire_s & ~rpt_dn_s)};
      case (next_state_s)
        SET_HOUR: sethms_r <= FIELD_HOUR;
        SET_MIN:  sethms_r <= FIELD_MIN;
        SET_SEC:  sethms_r <= FIELD_SEC;
        default:  sethms_r <= sethms_r;
      endcase
    end
  end

  // Idle timeout counter for the set states.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_r <= '0;
    end else if (!in_set_s || timeout_s || (ev_s != 4'b0000) || rpt_due_s) begin
      tmo_cnt_r <= '0;
    end else begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
    end
  end

  // Blink phase: solid in RUN, restarts dark on every field entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_r     <= 1'b1;
      blink_cnt_r <= '0;
    end else if (next_state_s == RUN) begin
      blink_r     <= 1'b1;
      blink_cnt_r <= '0;
    end else if (!stay_s) begin
      blink_r     <= 1'b0;
      blink_cnt_r <= '0;
    end else if (blink_cnt_r == BLK_W'(BLINK_HALF_CYCLES - 1)) begin
      blink_r     <= ~blink_r;
      blink_cnt_r <= '0;
    end else begin
      blink_cnt_r <= blink_cnt_r + BLK_W'(1);
    end
  end

`ifdef UI_AUTO_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                                    REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

  logic             rpt_arm_r;
  logic             rpt_dir_r;
  logic [RPT_W-1:0] rpt_cnt_r;
  logic             rpt_hold_s;

  assign rpt_hold_s = in_set_s && (level_s[KEY_UP] ^ level_s[KEY_DN]) &&
                      (level_s[KEY_DN] == rpt_dir_r);
  assign rpt_due_s  = rpt_arm_r && rpt_hold_s && (rpt_cnt_r == '0);
  assign rpt_dn_s   = rpt_dir_r;

  // Repeat timer: armed only by a real step pulse, so a key held across reset or entry stays silent.
  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_arm_r <= 1'b0;
      rpt_dir_r <= 1'b0;
      rpt_cnt_r <= '0;
    end else if ((step_up_s || step_dn_s) && stay_s) begin
      rpt_arm_r <= 1'b1;
      rpt_dir_r <= step_dn_s;
      rpt_cnt_r <= RPT_W'(REPEAT_DELAY_CYCLES - 1);
    end else if (!rpt_hold_s || !stay_s) begin
      rpt_arm_r <= 1'b0;
      rpt_cnt_r <= '0;
    end else if (rpt_arm_r && (rpt_cnt_r == '0)) begin
      rpt_cnt_r <= RPT_W'(REPEAT_PERIOD_CYCLES - 1);
    end else if (rpt_arm_r) begin
      rpt_cnt_r <= rpt_cnt_r - RPT_W'(1);
    end else begin
      rpt_cnt_r <= rpt_cnt_r;
    end
  end
`else
  assign rpt_due_s = 1'b0;
  assign rpt_dn_s  = 1'b0;
`endif

  assign set     = set_r;
  assign sethms  = sethms_r;
  assign upDown  = ud_r;
  assign blink   = blink_r;
  assign pressed = level_s;

endmodule

// File: tb/tb_ui_set_controller.sv
// Directed bench for ui_set_controller with short timing parameters.
// Expected auto-repeat count follows UI_AUTO_REPEAT_EN.
module tb_ui_set_controller;

  localparam int unsigned DC  = 4;
  localparam int unsigned RD  = 20;
  localparam int unsigned RP  = 5;
  localparam int unsigned TMO = 100;
  localparam int unsigned BH  = 8;

  logic       clk;
  logic       reset;
  logic [3:0] button;
  logic       set;
  logic [1:0] sethms;
  logic [1:0] upDown;
  logic       blink;
  logic [3:0] pressed;

  int n_checks = 0;
  int n_fail   = 0;
  int n_up     = 0;
  int n_dn     = 0;
  int u0;
  int d0;
  int exp_rpt;

  ui_set_controller #(
    .DEBOUNCE_CYCLES     (DC),
    .REPEAT_DELAY_CYCLES (RD),
    .REPEAT_PERIOD_CYCLES(RP),
    .TIMEOUT_CYCLES      (TMO),
    .BLINK_HALF_CYCLES   (BH)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .button (button),
    .set    (set),
    .sethms (sethms),
    .upDown (upDown),
    .blink  (blink),
    .pressed(pressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n cycles, sampling 1 time unit after each edge and tallying step pulses.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (upDown[0]) n_up++;
      if (upDown[1]) n_dn++;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full press and release of one key; returns with the key debounced-released.
  task automatic tap(input int k);
    button[k] = 1'b0;
    tick(7);
    button[k] = 1'b1;
    tick(7);
  endtask

  initial begin
    reset  = 1'b1;
    button = 4'b1111;
    tick(3);
    check("rst_set", 32'(set), 32'd0);
    check("rst_sethms", 32'(sethms), 32'd0);
    check("rst_updown", 32'(upDown), 32'd0);
    check("rst_blink", 32'(blink), 32'd1);
    check("rst_pressed", 32'(pressed), 32'd0);
    reset = 1'b0;
    tick(2);

    // Bounce filter: two 3-cycle glitches never reach the debounced level.
    button[0] = 1'b0; tick(3);
    button[0] = 1'b1; tick(3);
    button[0] = 1'b0; tick(3);
    button[0] = 1'b1; tick(3);
    check("bounce_level", 32'(pressed[0]), 32'd0);
    button[0] = 1'b0; tick(6);
    check("hold_n5", 32'(pressed[0]), 32'd0);
    tick(1);
    check("hold_n6", 32'(pressed[0]), 32'd1);
    tick(1);
    check("run_no_pulse", 32'(n_up), 32'd0);
    button[0] = 1'b1; tick(7);
    check("release", 32'(pressed[0]), 32'd0);

    // Field sequencing.
    tap(3);
    check("enter_set", 32'(set), 32'd1);
    check("enter_hour", 32'(sethms), 32'd2);
    check("blink_entry", 32'(blink), 32'd0);
    tick(2);
    check("blink_toggle", 32'(blink), 32'd1);
    tap(2);
    check("field_min", 32'(sethms), 32'd1);
    tap(2);
    check("field_sec", 32'(sethms), 32'd0);
    tap(2);
    check("field_hour", 32'(sethms), 32'd2);
    tap(3);
    check("exit_set", 32'(set), 32'd0);
    check("exit_blink", 32'(blink), 32'd1);
    check("exit_hold_field", 32'(sethms), 32'd2);

    // Step pulses in SET_MIN.
    tap(3);
    tap(2);
    check("step_field", 32'(sethms), 32'd1);
    u0 = n_up;
    d0 = n_dn;
    button[0] = 1'b0; tick(7);
    check("step_pre", 32'(upDown), 32'd0);
    check("step_level", 32'(pressed[0]), 32'd1);
    tick(1);
    check("step_pulse", 32'(upDown), 32'd1);
    tick(1);
    check("step_end", 32'(upDown), 32'd0);
    button[0] = 1'b1; tick(7);
    check("step_count", 32'(n_up - u0), 32'd1);
    button[1:0] = 2'b00; tick(8);
    check("both_pulse", 32'(upDown), 32'd0);
    button[1:0] = 2'b11; tick(7);
    check("both_up_count", 32'(n_up - u0), 32'd1);
    check("both_dn_count", 32'(n_dn - d0), 32'd0);
    tap(3);
    check("step_exit", 32'(set), 32'd0);

    // Idle timeout, then a press on the last idle cycle restarts it.
    button[3] = 1'b0; tick(7);
    button[3] = 1'b1; tick(1);
    check("tmo_enter", 32'(set), 32'd1);
    tick(99);
    check("tmo_99", 32'(set), 32'd1);
    tick(1);
    check("tmo_100", 32'(set), 32'd0);
    button[3] = 1'b0; tick(7);
    button[3] = 1'b1; tick(1);
    tick(92);
    button[0] = 1'b0; tick(7);
    check("tmo_press_99", 32'(set), 32'd1);
    tick(1);
    check("tmo_restart_set", 32'(set), 32'd1);
    check("tmo_restart_pulse", 32'(upDown), 32'd1);
    button[0] = 1'b1;
    tick(99);
    check("tmo2_99", 32'(set), 32'd1);
    tick(1);
    check("tmo2_100", 32'(set), 32'd0);

    // Auto-repeat window: offset 0 through 60 after the press pulse.
`ifdef UI_AUTO_REPEAT_EN
    exp_rpt = 10;
`else
    exp_rpt = 1;
`endif
    tap(3);
    button[1] = 1'b0; tick(7);
    d0 = n_dn;
    tick(61);
    check("repeat_count", 32'(n_dn - d0), 32'(exp_rpt));
    button[1] = 1'b1; tick(8);
    check("repeat_still_set", 32'(set), 32'd1);

    // Reset in SET_SEC while key0 is held.
    tap(2);
    tap(2);
    check("rst_pre_sec", 32'(sethms), 32'd0);
    button[0] = 1'b0; tick(8);
    tick(3);
    reset = 1'b1; tick(1);
    check("mid_rst_set", 32'(set), 32'd0);
    check("mid_rst_updown", 32'(upDown), 32'd0);
    check("mid_rst_blink", 32'(blink), 32'd1);
    check("mid_rst_pressed", 32'(pressed), 32'd0);
    check("mid_rst_sethms", 32'(sethms), 32'd0);
    reset = 1'b0;
    u0 = n_up;
    tick(20);
    check("post_rst_held", 32'(pressed), 32'd1);
    check("post_rst_run", 32'(set), 32'd0);
    tap(3);
    tick(30);
    check("post_rst_no_pulse", 32'(n_up - u0), 32'd0);
    button[0] = 1'b1; tick(7);
    button[0] = 1'b0; tick(8);
    check("fresh_pulse", 32'(upDown), 32'd1);
    check("fresh_count", 32'(n_up - u0), 32'd1);
    button[0] = 1'b1; tick(8);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
